dmem_responder: RTL and testbench

//   Data-memory responder serving load/store requests issued by the core datapath
//   (ALUResult as address, writeData as store data, memWrite as write strobe).

---
 rtl/dmem_responder_if.sv | 26 ++
 rtl/dmem_responder.sv | 185 ++++++++++++++++++
 tb/tb_dmem_responder.sv | 209 ++++++++++++++++++++
 3 files changed

// File: rtl/dmem_responder_if.sv
// Request/response bus between the core datapath and the data-memory responder.
// The master drives the request channel and resp_ready. The slave (responder)
// drives req_ready and the response channel.
interface dmem_responder_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic [1:0]  req_size;
    logic        req_unsigned;
    logic        resp_valid;
    logic        resp_ready;
    logic [31:0] resp_rdata;
    logic        resp_err;

    modport master (
        output req_valid, req_write, req_addr, req_wdata, req_size, req_unsigned, resp_ready,
        input  req_ready, resp_valid, resp_rdata, resp_err
    );

    modport slave (
        input  req_valid, req_write, req_addr, req_wdata, req_size, req_unsigned, resp_ready,
        output req_ready, resp_valid, resp_rdata, resp_err
    );
endinterface

// File: rtl/dmem_responder.sv
// Data-memory responder: one outstanding load/store, fixed latency, byte/half/word
// little-endian access with load extension and alignment/range fault detection.
module dmem_responder #(
    parameter int          DEPTH_WORDS = 1024,
    parameter int          LATENCY     = 2,
    parameter logic [31:0] BASE_ADDR   = 32'h0
) (
    input  logic             clk,
    input  logic             reset_n,
    dmem_responder_if.slave  bus
);
    localparam int          AW       = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
    localparam logic [32:0] SPAN     = 33'(DEPTH_WORDS) << 2;
    localparam logic [3:0]  LAT_LOAD = 4'(LATENCY - 1);

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    state_t      state_reg;
    logic [3:0]  count_reg;
    logic        write_reg;
    logic [31:0] addr_reg;
    logic [31:0] wdata_reg;
    logic [1:0]  size_reg;
    logic        unsigned_reg;
    logic        resp_valid_reg;
    logic [31:0] resp_rdata_reg;
    logic        resp_err_reg;

    // A LATENCY==1 request commits on its accept edge, before the latches hold it,
    // so the access is decoded from the live inputs while in IDLE.
    logic        cur_write;
    logic [31:0] cur_addr;
    logic [31:0] cur_wdata;
    logic [1:0]  cur_size;
    logic        cur_unsigned;

    assign cur_write    = (state_reg == IDLE) ? bus.req_write    : write_reg;
    assign cur_addr     = (state_reg == IDLE) ? bus.req_addr     : addr_reg;
    assign cur_wdata    = (state_reg == IDLE) ? bus.req_wdata    : wdata_reg;
    assign cur_size     = (state_reg == IDLE) ? bus.req_size     : size_reg;
    assign cur_unsigned = (state_reg == IDLE) ? bus.req_unsigned : unsigned_reg;

    logic accept;
    logic commit;

    assign bus.req_ready = (state_reg == IDLE) && reset_n;
    assign accept        = bus.req_valid && bus.req_ready;
    assign commit        = reset_n &&
                           (((LATENCY == 1) && accept) ||
                            ((state_reg == WAIT) && (count_reg == 4'd1)));

    // The 33-bit offset makes an address below BASE_ADDR show up as a borrow.
    logic [32:0]   offset;
    logic          range_fault;
    logic          align_fault;
    logic          fault;
    logic [AW-1:0] widx;

    assign offset      = {1'b0, cur_addr} - {1'b0, BASE_ADDR};
    assign range_fault = offset[32] || (offset >= SPAN);
    assign fault       = range_fault || align_fault;
    assign widx        = offset[AW+1:2];

    logic [3:0]  lane_en;
    logic [31:0] lane_wdata;

    // Alignment check, byte-lane enables and lane-replicated store data
    always_comb begin
        align_fault = 1'b0;
        lane_en     = 4'b0000;
        lane_wdata  = cur_wdata;
        case (cur_size)
            2'b00: begin
                lane_en    = 4'b0001 << cur_addr[1:0];
                lane_wdata = {4{cur_wdata[7:0]}};
            end
            2'b01: begin
                align_fault = cur_addr[0];
                lane_en     = cur_addr[1] ? 4'b1100 : 4'b0011;
                lane_wdata  = {2{cur_wdata[15:0]}};
            end
            2'b10: begin
                align_fault = (cur_addr[1:0] != 2'b00);
                lane_en     = 4'b1111;
            end
            default: begin
                align_fault = 1'b1;
            end
        endcase
    end

    logic [31:0] rd_word;

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_lane
            logic [7:0] mem [DEPTH_WORDS];

            // Byte lane written only when a non-faulting store commits
            always_ff @(posedge clk) begin
                if (commit && cur_write && !fault && lane_en[gi]) begin
                    mem[widx] <= lane_wdata[8*gi +: 8];
                end
            end

            assign rd_word[8*gi +: 8] = mem[widx];
        end
    endgenerate

    logic [31:0] shifted;
    logic [31:0] load_data;
    logic [31:0] rdata_next;

    assign shifted = rd_word >> {cur_addr[1:0], 3'b000};

    // Extract the addressed lanes and extend; stores and faults return zero
    always_comb begin
        load_data = 32'h0;
        case (cur_size)
            2'b00:   load_data = cur_unsigned ? {24'h0, shifted[7:0]}
                                              : {{24{shifted[7]}}, shifted[7:0]};
            2'b01:   load_data = cur_unsigned ? {16'h0, shifted[15:0]}
                                              : {{16{shifted[15]}}, shifted[15:0]};
            2'b10:   load_data = shifted;
            default: load_data = 32'h0;
        endcase
        rdata_next = (cur_write || fault) ? 32'h0 : load_data;
    end

    // Control FSM: accept, latency countdown, response hold until handoff
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_reg      <= IDLE;
            count_reg      <= 4'd0;
            resp_valid_reg <= 1'b0;
            resp_rdata_reg <= 32'h0;
            resp_err_reg   <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (accept) begin
                        write_reg    <= bus.req_write;
                        addr_reg     <= bus.req_addr;
                        wdata_reg    <= bus.req_wdata;
                        size_reg     <= bus.req_size;
                        unsigned_reg <= bus.req_unsigned;
                        count_reg    <= LAT_LOAD;
                        if (LATENCY == 1) begin
                            state_reg      <= RESP;
                            resp_valid_reg <= 1'b1;
                            resp_rdata_reg <= rdata_next;
                            resp_err_reg   <= fault;
                        end else begin
                            state_reg <= WAIT;
                        end
                    end
                end
                WAIT: begin
                    count_reg <= count_reg - 4'd1;
                    if (count_reg == 4'd1) begin
                        state_reg      <= RESP;
                        resp_valid_reg <= 1'b1;
                        resp_rdata_reg <= rdata_next;
                        resp_err_reg   <= fault;
                    end
                end
                RESP: begin
                    if (bus.resp_ready) begin
                        state_reg      <= IDLE;
                        resp_valid_reg <= 1'b0;
                        resp_rdata_reg <= 32'h0;
                        resp_err_reg   <= 1'b0;
                    end
                end
                default: begin
                    state_reg <= IDLE;
                end
            endcase
        end
    end

    assign bus.resp_valid = resp_valid_reg;
    assign bus.resp_rdata = resp_rdata_reg;
    assign bus.resp_err   = resp_err_reg;
endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder: instance A (LATENCY=2) covers data paths,
// faults and backpressure; instance B (LATENCY=4) covers reset during WAIT.
module tb_dmem_responder;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_a_n;
    logic        rst_b_n;
    logic        sel;
    logic        req_valid;
    logic        req_write;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic [1:0]  req_size;
    logic        req_unsigned;
    logic        resp_ready;

    dmem_responder_if bus_a ();
    dmem_responder_if bus_b ();

    assign bus_a.req_valid    = req_valid && !sel;
    assign bus_a.req_write    = req_write;
    assign bus_a.req_addr     = req_addr;
    assign bus_a.req_wdata    = req_wdata;
    assign bus_a.req_size     = req_size;
    assign bus_a.req_unsigned = req_unsigned;
    assign bus_a.resp_ready   = resp_ready && !sel;

    assign bus_b.req_valid    = req_valid && sel;
    assign bus_b.req_write    = req_write;
    assign bus_b.req_addr     = req_addr;
    assign bus_b.req_wdata    = req_wdata;
    assign bus_b.req_size     = req_size;
    assign bus_b.req_unsigned = req_unsigned;
    assign bus_b.resp_ready   = resp_ready && sel;

    dmem_responder #(.LATENCY(2)) u_a (.clk(clk), .reset_n(rst_a_n), .bus(bus_a.slave));
    dmem_responder #(.LATENCY(4)) u_b (.clk(clk), .reset_n(rst_b_n), .bus(bus_b.slave));

    logic        obs_ready;
    logic        obs_valid;
    logic [31:0] obs_rdata;
    logic        obs_err;

    assign obs_ready = sel ? bus_b.req_ready  : bus_a.req_ready;
    assign obs_valid = sel ? bus_b.resp_valid : bus_a.resp_valid;
    assign obs_rdata = sel ? bus_b.resp_rdata : bus_a.resp_rdata;
    assign obs_err   = sel ? bus_b.resp_err   : bus_a.resp_err;

    int passes = 0;
    int checks = 0;
    int fails  = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) begin
            passes++;
        end else begin
            fails++;
            $error("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // One request on the selected instance; called and returning at a falling edge
    task automatic txn(input string tag, input logic wr, input logic [31:0] addr,
                       input logic [31:0] wdata, input logic [1:0] size, input logic uns,
                       input logic [31:0] exp_rdata, input logic exp_err, input int hold);
        int          lat;
        logic        early;
        logic        stable;
        logic [31:0] snap;
        lat = sel ? 4 : 2;
        chk({tag, "/req_ready"}, 32'(obs_ready), 32'd1);
        req_valid    = 1'b1;
        req_write    = wr;
        req_addr     = addr;
        req_wdata    = wdata;
        req_size     = size;
        req_unsigned = uns;
        resp_ready   = (hold == 0);
        @(posedge clk);
        @(negedge clk);
        // Scramble inputs after accept: the responder must use its latched copy
        req_valid    = 1'b0;
        req_write    = ~wr;
        req_addr     = $urandom;
        req_wdata    = $urandom;
        req_size     = 2'(~size);
        req_unsigned = ~uns;
        early = 1'b0;
        for (int k = 1; k < lat; k++) begin
            early |= obs_valid;
            @(negedge clk);
        end
        chk({tag, "/early_valid"}, 32'(early), 32'd0);
        chk({tag, "/resp_valid"}, 32'(obs_valid), 32'd1);
        chk({tag, "/rdata"}, obs_rdata, exp_rdata);
        chk({tag, "/err"}, 32'(obs_err), 32'(exp_err));
        if (hold > 0) begin
            stable = 1'b1;
            snap   = obs_rdata;
            for (int k = 0; k < hold; k++) begin
                if (!obs_valid || (obs_rdata !== snap) || obs_ready) stable = 1'b0;
                @(negedge clk);
            end
            chk({tag, "/held_stable"}, 32'(stable), 32'd1);
            resp_ready = 1'b1;
        end
        $display("txn %s inst=%0d wr=%0d addr=%h size=%0d rdata=%h err=%0d",
                 tag, sel, wr, addr, size, obs_rdata, obs_err);
        @(negedge clk);
        chk({tag, "/valid_after"}, 32'(obs_valid), 32'd0);
        chk({tag, "/ready_after"}, 32'(obs_ready), 32'd1);
    endtask

    initial begin
        logic early;
        sel          = 1'b0;
        req_valid    = 1'b0;
        req_write    = 1'b0;
        req_addr     = 32'h0;
        req_wdata    = 32'h0;
        req_size     = 2'b10;
        req_unsigned = 1'b0;
        resp_ready   = 1'b1;
        rst_a_n      = 1'b0;
        rst_b_n      = 1'b0;

        // Reset held three cycles
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst/a_req_ready", 32'(bus_a.req_ready), 32'd0);
        chk("rst/a_resp_valid", 32'(bus_a.resp_valid), 32'd0);
        chk("rst/a_resp_rdata", bus_a.resp_rdata, 32'h0);
        chk("rst/a_resp_err", 32'(bus_a.resp_err), 32'd0);
        chk("rst/b_req_ready", 32'(bus_b.req_ready), 32'd0);
        chk("rst/b_resp_valid", 32'(bus_b.resp_valid), 32'd0);
        rst_a_n = 1'b1;
        rst_b_n = 1'b1;
        @(negedge clk);
        chk("rst/a_ready_after", 32'(bus_a.req_ready), 32'd1);
        chk("rst/b_ready_after", 32'(bus_b.req_ready), 32'd1);

        // Word store then load
        txn("st_w_10", 1'b1, 32'h10, 32'hDEADBEEF, 2'b10, 1'b0, 32'h0, 1'b0, 0);
        txn("ld_w_10", 1'b0, 32'h10, 32'h0, 2'b10, 1'b0, 32'hDEADBEEF, 1'b0, 0);

        // Byte and half lanes with sign/zero extension
        txn("st_w_20", 1'b1, 32'h20, 32'h00000000, 2'b10, 1'b0, 32'h0, 1'b0, 0);
        txn("st_b_21", 1'b1, 32'h21, 32'hFFFFFF80, 2'b00, 1'b0, 32'h0, 1'b0, 0);
        txn("ld_bs_21", 1'b0, 32'h21, 32'h0, 2'b00, 1'b0, 32'hFFFFFF80, 1'b0, 0);
        txn("ld_bu_21", 1'b0, 32'h21, 32'h0, 2'b00, 1'b1, 32'h00000080, 1'b0, 0);
        txn("ld_w_20", 1'b0, 32'h20, 32'h0, 2'b10, 1'b0, 32'h00008000, 1'b0, 0);
        txn("st_h_22", 1'b1, 32'h22, 32'h12348001, 2'b01, 1'b0, 32'h0, 1'b0, 0);
        txn("ld_w_20b", 1'b0, 32'h20, 32'h0, 2'b10, 1'b0, 32'h80018000, 1'b0, 0);
        txn("ld_hs_22", 1'b0, 32'h22, 32'h0, 2'b01, 1'b0, 32'hFFFF8001, 1'b0, 0);
        txn("ld_hs_20", 1'b0, 32'h20, 32'h0, 2'b01, 1'b0, 32'hFFFF8000, 1'b0, 0);
        txn("ld_hu_20", 1'b0, 32'h20, 32'h0, 2'b01, 1'b1, 32'h00008000, 1'b0, 0);
        txn("ld_bu_23", 1'b0, 32'h23, 32'h0, 2'b00, 1'b1, 32'h00000080, 1'b0, 0);

        // Faults leave memory untouched
        txn("st_w_0", 1'b1, 32'h0, 32'h11223344, 2'b10, 1'b0, 32'h0, 1'b0, 0);
        txn("st_w_4", 1'b1, 32'h4, 32'h11223344, 2'b10, 1'b0, 32'h0, 1'b0, 0);
        txn("f_ld_h_3", 1'b0, 32'h3, 32'h0, 2'b01, 1'b0, 32'h0, 1'b1, 0);
        txn("f_st_w_6", 1'b1, 32'h6, 32'h55555555, 2'b10, 1'b0, 32'h0, 1'b1, 0);
        txn("f_st_sz3", 1'b1, 32'h4, 32'hAAAAAAAA, 2'b11, 1'b0, 32'h0, 1'b1, 0);
        txn("f_ld_sz3", 1'b0, 32'h0, 32'h0, 2'b11, 1'b0, 32'h0, 1'b1, 0);
        txn("f_st_1000", 1'b1, 32'h1000, 32'h99999999, 2'b10, 1'b0, 32'h0, 1'b1, 0);
        txn("f_ld_1000", 1'b0, 32'h1000, 32'h0, 2'b10, 1'b0, 32'h0, 1'b1, 0);
        txn("f_ld_fffc", 1'b0, 32'hFFFFFFFC, 32'h0, 2'b10, 1'b0, 32'h0, 1'b1, 0);
        txn("ld_w_0", 1'b0, 32'h0, 32'h0, 2'b10, 1'b0, 32'h11223344, 1'b0, 0);
        txn("ld_w_4", 1'b0, 32'h4, 32'h0, 2'b10, 1'b0, 32'h11223344, 1'b0, 0);
        txn("ld_hu_2", 1'b0, 32'h2, 32'h0, 2'b01, 1'b1, 32'h00001122, 1'b0, 0);
        txn("st_w_ffc", 1'b1, 32'hFFC, 32'h0F0F0F0F, 2'b10, 1'b0, 32'h0, 1'b0, 0);
        txn("ld_w_ffc", 1'b0, 32'hFFC, 32'h0, 2'b10, 1'b0, 32'h0F0F0F0F, 1'b0, 0);

        // Backpressure: response held ten cycles
        txn("bp_ld_10", 1'b0, 32'h10, 32'h0, 2'b10, 1'b0, 32'hDEADBEEF, 1'b0, 10);

        // Instance B: reset one cycle into WAIT discards the store
        sel = 1'b1;
        txn("b_st_40", 1'b1, 32'h40, 32'hCAFEF00D, 2'b10, 1'b0, 32'h0, 1'b0, 0);
        txn("b_ld_40", 1'b0, 32'h40, 32'h0, 2'b10, 1'b0, 32'hCAFEF00D, 1'b0, 0);
        req_valid = 1'b1;
        req_write = 1'b1;
        req_addr  = 32'h40;
        req_wdata = 32'h12345678;
        req_size  = 2'b10;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        rst_b_n   = 1'b0;
        @(posedge clk);
        @(negedge clk);
        chk("b_rst/ready_in_reset", 32'(obs_ready), 32'd0);
        rst_b_n = 1'b1;
        early = 1'b0;
        for (int k = 0; k < 6; k++) begin
            early |= obs_valid;
            @(negedge clk);
        end
        $display("txn b_rst_st_40 inst=1 wr=1 addr=00000040 reset during WAIT");
        chk("b_rst/no_resp", 32'(early), 32'd0);
        txn("b_ld_40_after", 1'b0, 32'h40, 32'h0, 2'b10, 1'b0, 32'hCAFEF00D, 1'b0, 0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
